// File: rtl/lcd_hd44780_responder_pkg.sv
// Shared constants, FSM states and address-counter stepping for the HD44780 responder.
package lcd_hd44780_responder_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 128;

  localparam logic [ADDR_W-1:0] LINE0_BASE    = 7'h00;
  localparam logic [ADDR_W-1:0] LINE0_LAST    = 7'h27;
  localparam logic [ADDR_W-1:0] LINE1_BASE    = 7'h40;
  localparam logic [ADDR_W-1:0] LINE1_LAST    = 7'h67;
  localparam logic [ADDR_W-1:0] ONE_LINE_LAST = 7'h4F;
  localparam logic [DATA_W-1:0] ASCII_SPACE   = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_FILL,
    ST_WAIT
  } state_t;

  typedef struct packed {
    logic              rs;
    logic [DATA_W-1:0] data;
  } host_wr_t;

  // Step the address counter by one with the display's line wrap rules.
  function automatic logic [ADDR_W-1:0] ac_step(input logic [ADDR_W-1:0] ac,
                                                input logic up, input logic two_line);
    logic [ADDR_W-1:0] r;
    if (two_line) begin
      if (up) r = (ac == LINE0_LAST) ? LINE1_BASE : (ac == LINE1_LAST) ? LINE0_BASE : ac + 7'd1;
      else    r = (ac == LINE0_BASE) ? LINE1_LAST : (ac == LINE1_BASE) ? LINE0_LAST : ac - 7'd1;
    end else begin
      if (up) r = (ac == ONE_LINE_LAST) ? LINE0_BASE : ac + 7'd1;
      else    r = (ac == LINE0_BASE) ? ONE_LINE_LAST : ac - 7'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lcd_hd44780_responder_if.sv
// Host-side 8-bit write-only HD44780 bus.
interface lcd_hd44780_responder_if;
  import lcd_hd44780_responder_pkg::*;

  logic              en;
  logic              rs;
  logic [DATA_W-1:0] data;

  modport master (output en, output rs, output data);
  modport slave  (input en, input rs, input data);
endinterface

// File: rtl/lcd_hd44780_responder_ddram.sv
// 128x8 display data RAM: one synchronous write port, one registered scan read port.
module lcd_hd44780_responder_ddram
  import lcd_hd44780_responder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Reads in the same cycle as a write to that address return the old byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rdata <= '0;
    else      r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// Display-side HD44780 stand-in: syncs the host bus, commits writes on en falling edge,
// executes them against DDRAM and mode registers and models busy time.
module lcd_hd44780_responder
  import lcd_hd44780_responder_pkg::*;
#(
  parameter int unsigned MIN_EN_HIGH  = 8,
  parameter int unsigned EXEC_CYCLES  = 1000,
  parameter int unsigned CLEAR_CYCLES = 80000
) (
  input  logic                   clk,
  input  logic                   rst,
  lcd_hd44780_responder_if.slave bus,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   busy,
  output logic [ADDR_W-1:0]      cur_addr,
  output logic                   disp_on,
  output logic                   cursor_on,
  output logic                   blink_on,
  output logic                   incr,
  output logic                   two_line,
  output logic                   wr_stb,
  output logic                   err
);

  localparam int unsigned HI_W  = $clog2(MIN_EN_HIGH + 2);
  localparam int unsigned CNT_W = 32;
  // Remaining WAIT cycles once EXEC (and FILL) have been spent.
  localparam logic [CNT_W-1:0] EXEC_WAIT  = CNT_W'((EXEC_CYCLES > 2) ? EXEC_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] CLEAR_WAIT = CNT_W'((CLEAR_CYCLES > 2) ? CLEAR_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] FILL_WAIT  = CNT_W'((CLEAR_CYCLES > 82) ? CLEAR_CYCLES - 82 : 0);

  logic              r_en_m, r_en_s, r_en_d;
  logic              r_rs_m, r_rs_s;
  logic [DATA_W-1:0] r_data_m, r_data_s;
  logic [HI_W-1:0]   r_hi;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  host_wr_t          r_cmd, w_cmd_nxt;
  logic [ADDR_W-1:0] r_ac, w_ac_nxt;
  logic [ADDR_W-1:0] r_fill, w_fill_nxt;
  logic              r_n, w_n_nxt, r_d, w_d_nxt, r_c, w_c_nxt, r_b, w_b_nxt, r_i, w_i_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_wr_stb, w_wr_stb_nxt;
  logic              r_err, w_err_nxt;

  logic              w_fall, w_long, w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  // Two-flop sync on every bus line keeps rs/data aligned with en; high-width counter saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en_m <= 1'b0; r_en_s <= 1'b0; r_en_d <= 1'b0;
      r_rs_m <= 1'b0; r_rs_s <= 1'b0;
      r_data_m <= '0; r_data_s <= '0;
      r_hi <= '0;
    end else begin
      r_en_m <= bus.en;   r_en_s <= r_en_m;   r_en_d <= r_en_s;
      r_rs_m <= bus.rs;   r_rs_s <= r_rs_m;
      r_data_m <= bus.data; r_data_s <= r_data_m;
      if (!r_en_s)                           r_hi <= '0;
      else if (r_hi != HI_W'(MIN_EN_HIGH))   r_hi <= r_hi + HI_W'(1);
    end
  end

  assign w_fall = r_en_d & ~r_en_s;
  assign w_long = (r_hi >= HI_W'(MIN_EN_HIGH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE; r_cnt <= '0; r_cmd <= '0; r_ac <= '0; r_fill <= '0;
      r_n <= 1'b0; r_d <= 1'b0; r_c <= 1'b0; r_b <= 1'b0; r_i <= 1'b1;
      r_busy <= 1'b0; r_wr_stb <= 1'b0; r_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt; r_cnt <= w_cnt_nxt; r_cmd <= w_cmd_nxt; r_ac <= w_ac_nxt;
      r_fill <= w_fill_nxt;
      r_n <= w_n_nxt; r_d <= w_d_nxt; r_c <= w_c_nxt; r_b <= w_b_nxt; r_i <= w_i_nxt;
      r_busy <= w_busy_nxt; r_wr_stb <= w_wr_stb_nxt; r_err <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;  w_cnt_nxt = r_cnt;  w_cmd_nxt = r_cmd;  w_ac_nxt = r_ac;
    w_fill_nxt = r_fill;
    w_n_nxt = r_n; w_d_nxt = r_d; w_c_nxt = r_c; w_b_nxt = r_b; w_i_nxt = r_i;
    w_wr_stb_nxt = 1'b0; w_err_nxt = 1'b0;
    w_we = 1'b0; w_waddr = r_ac; w_wdata = r_cmd.data;

    // Commit: busy is sampled as registered, so an edge coinciding with busy release is rejected.
    if (w_fall) begin
      if (r_busy || !w_long) begin
        w_err_nxt = 1'b1;
      end else begin
        w_wr_stb_nxt = 1'b1;
        w_cmd_nxt    = '{rs: r_rs_s, data: r_data_s};
        w_state_nxt  = ST_EXEC;
      end
    end

    case (r_state)
      ST_EXEC: begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = EXEC_WAIT;
        if (r_cmd.rs) begin
          w_we     = 1'b1;
          w_ac_nxt = ac_step(r_ac, r_i, r_n);
        end else begin
          casez (r_cmd.data)
            8'b1???????: w_ac_nxt = r_cmd.data[6:0];
            8'b01??????: ;
            8'b001?????: w_n_nxt = r_cmd.data[3];
            8'b0001????: w_ac_nxt = ac_step(r_ac, r_cmd.data[2], r_n);
            8'b00001???: {w_d_nxt, w_c_nxt, w_b_nxt} = r_cmd.data[2:0];
            8'b000001??: w_i_nxt = r_cmd.data[1];
            8'b0000001?: begin
              w_ac_nxt  = '0;
              w_cnt_nxt = CLEAR_WAIT;
            end
            8'b00000001: begin
              w_state_nxt = ST_FILL;
              w_fill_nxt  = LINE0_BASE;
            end
            default: ;
          endcase
        end
      end
      ST_FILL: begin
        w_we    = 1'b1;
        w_waddr = r_fill;
        w_wdata = ASCII_SPACE;
        if (r_fill == LINE1_LAST) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = FILL_WAIT;
          w_ac_nxt    = '0;
          w_i_nxt     = 1'b1;
        end else begin
          w_fill_nxt = ac_step(r_fill, 1'b1, 1'b1);
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) w_state_nxt = ST_IDLE;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      default: ;
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  lcd_hd44780_responder_ddram u_ddram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

  assign busy      = r_busy;
  assign cur_addr  = r_ac;
  assign disp_on   = r_d;
  assign cursor_on = r_c;
  assign blink_on  = r_b;
  assign incr      = r_i;
  assign two_line  = r_n;
  assign wr_stb    = r_wr_stb;
  assign err       = r_err;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Randomized self-checking bench for lcd_hd44780_responder against a behavioural display model.
module tb_lcd_hd44780_responder;

  localparam int unsigned MINH = 8;
  localparam int unsigned EXEC = 60;
  localparam int unsigned CLR  = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy, disp_on, cursor_on, blink_on, incr, two_line, wr_stb, err;
  logic [6:0] cur_addr;

  always #5 clk = ~clk;

  lcd_hd44780_responder_if bus ();

  lcd_hd44780_responder #(.MIN_EN_HIGH(MINH), .EXEC_CYCLES(EXEC), .CLEAR_CYCLES(CLR)) dut (
    .clk(clk), .rst(rst), .bus(bus), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
    .cur_addr(cur_addr), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .incr(incr), .two_line(two_line), .wr_stb(wr_stb), .err(err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int stb_cnt  = 0;
  int err_cnt  = 0;

  always @(negedge clk) begin
    if (wr_stb === 1'b1) stb_cnt++;
    if (err === 1'b1)    err_cnt++;
  end

  // Behavioural display model.
  logic [7:0] m_mem   [128];
  bit         m_known [128];
  logic [6:0] m_ac;
  bit         m_n, m_d, m_c, m_b, m_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [6:0] m_step(input logic [6:0] a, input bit up);
    if (m_n) begin
      if (up) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
      else    return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
    end
    if (up) return (a == 7'h4F) ? 7'h00 : a + 7'd1;
    return (a == 7'h00) ? 7'h4F : a - 7'd1;
  endfunction

  task automatic m_reset_regs();
    m_ac = 7'h00; m_n = 0; m_d = 0; m_c = 0; m_b = 0; m_i = 1;
  endtask

  task automatic m_apply(input bit rs_i, input logic [7:0] d);
    if (rs_i) begin
      m_mem[m_ac] = d; m_known[m_ac] = 1; m_ac = m_step(m_ac, m_i);
    end
    else if (d[7]) m_ac = d[6:0];
    else if (d[6]) ;
    else if (d[5]) m_n = d[3];
    else if (d[4]) m_ac = m_step(m_ac, d[2]);
    else if (d[3]) {m_d, m_c, m_b} = d[2:0];
    else if (d[2]) m_i = d[1];
    else if (d[1]) m_ac = 7'h00;
    else if (d[0]) begin
      for (int k = 0; k < 40; k++) begin
        m_mem[k] = 8'h20;        m_known[k] = 1;
        m_mem[k + 64] = 8'h20;   m_known[k + 64] = 1;
      end
      m_ac = 7'h00; m_i = 1;
    end
  endtask

  // One en pulse of hi clocks; returns at 4 clocks after the en falling edge.
  task automatic host_write(input bit rs_i, input logic [7:0] d, input int hi,
                            output bit acc, output bit rej);
    int s0, e0;
    @(negedge clk);
    bus.rs = rs_i; bus.data = d; bus.en = 1'b1;
    repeat (hi) @(negedge clk);
    s0 = stb_cnt; e0 = err_cnt;
    bus.en = 1'b0;
    repeat (4) @(negedge clk);
    acc = (stb_cnt != s0);
    rej = (err_cnt != e0);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "/idle"}, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "/ac"}, 32'(cur_addr), 32'(m_ac));
    chk({tag, "/mode"}, 32'({two_line, disp_on, cursor_on, blink_on, incr}),
        32'({m_n, m_d, m_c, m_b, m_i}));
  endtask

  task automatic accept_write(input bit rs_i, input logic [7:0] d, input int hi, input string tag);
    bit acc, rej;
    host_write(rs_i, d, hi, acc, rej);
    chk({tag, "/wr_stb"}, 32'(acc), 32'd1);
    chk({tag, "/err"}, 32'(rej), 32'd0);
    if (acc) begin
      m_apply(rs_i, d);
      if (rs_i || d != 8'h01) chk({tag, "/ac_latency"}, 32'(cur_addr), 32'(m_ac));
    end
  endtask

  task automatic do_write(input bit rs_i, input logic [7:0] d, input int hi, input string tag);
    accept_write(rs_i, d, hi, tag);
    wait_idle(tag);
    chk_regs(tag);
  endtask

  task automatic reject_write(input bit rs_i, input logic [7:0] d, input int hi, input string tag);
    bit acc, rej;
    host_write(rs_i, d, hi, acc, rej);
    chk({tag, "/wr_stb"}, 32'(acc), 32'd0);
    chk({tag, "/err"}, 32'(rej), 32'd1);
    chk({tag, "/ac_kept"}, 32'(cur_addr), 32'(m_ac));
  endtask

  task automatic scan_chk(input logic [6:0] a);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    if (m_known[a]) chk($sformatf("ddram[%02h]", a), 32'(rd_data), 32'(m_mem[a]));
  endtask

  logic [7:0] init_seq [7] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h06, 8'h01};

  initial begin
    int  e0;
    bit  rs_r;
    logic [7:0] d_r;
    rst = 1'b0; bus.en = 1'b0; bus.rs = 1'b0; bus.data = 8'h00; rd_addr = 7'h00;
    for (int k = 0; k < 128; k++) begin m_known[k] = 0; m_mem[k] = 8'h00; end
    m_reset_regs();
    repeat (5) @(negedge clk);
    chk("reset/busy", 32'(busy), 32'd0);
    chk("reset/rd_data", 32'(rd_data), 32'd0);
    chk("reset/pulses", 32'({wr_stb, err}), 32'd0);
    chk_regs("reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Standard init sequence.
    e0 = err_cnt;
    foreach (init_seq[k]) do_write(1'b0, init_seq[k], 13, $sformatf("init%0d", k));
    chk("init/no_err", 32'(err_cnt - e0), 32'd0);

    do_write(1'b1, 8'h4D, 13, "M");
    do_write(1'b1, 8'h41, 13, "A");
    do_write(1'b1, 8'h52, 13, "R");
    for (int k = 0; k < 3; k++) scan_chk(7'(k));

    do_write(1'b0, 8'hA7, 13, "ac27");
    do_write(1'b1, 8'h58, 13, "X");
    do_write(1'b1, 8'h59, 13, "Y");
    scan_chk(7'h27); scan_chk(7'h40);

    do_write(1'b0, 8'h04, 13, "dec");
    do_write(1'b0, 8'h80, 13, "ac00");
    do_write(1'b1, 8'h5A, 13, "Z");
    scan_chk(7'h00);

    // Write during busy, then pulse-width boundaries.
    do_write(1'b0, 8'h06, 13, "inc");
    accept_write(1'b1, 8'h71, 13, "busy1");
    repeat (8) @(negedge clk);
    reject_write(1'b1, 8'h72, 13, "busy2");
    wait_idle("busy2");
    chk_regs("busy2");
    reject_write(1'b1, 8'h73, 4, "short4");
    reject_write(1'b1, 8'h74, MINH - 1, "short7");
    do_write(1'b1, 8'h75, MINH, "min8");
    scan_chk(7'h01); scan_chk(7'h02); scan_chk(7'h03);

    // Randomized command/data mix.
    for (int n = 0; n < 40; n++) begin
      rs_r = 1'b0;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin rs_r = 1'b1; d_r = 8'($urandom_range(8'h21, 8'h7E)); end
        4: d_r = 8'h80 | 8'($urandom_range(0, 127));
        5: d_r = 8'h10 | 8'($urandom_range(0, 15));
        6: d_r = 8'h04 | 8'($urandom_range(0, 3));
        7: d_r = 8'h08 | 8'($urandom_range(0, 7));
        8: d_r = 8'h20 | 8'($urandom_range(0, 31));
        default: case ($urandom_range(0, 4))
          0: d_r = 8'h00;
          1: d_r = 8'h02;
          2: d_r = 8'h03;
          3: d_r = 8'h01;
          default: d_r = 8'h40 | 8'($urandom_range(0, 63));
        endcase
      endcase
      case ($urandom_range(0, 5))
        0: begin
          accept_write(rs_r, d_r, 12, "rnd_b");
          repeat ($urandom_range(2, 10)) @(negedge clk);
          reject_write(1'b1, 8'($urandom), 13, "rnd_busy");
          wait_idle("rnd_b");
          chk_regs("rnd_b");
        end
        1: begin
          reject_write(1'b1, 8'($urandom), $urandom_range(1, MINH - 1), "rnd_short");
          do_write(rs_r, d_r, $urandom_range(MINH, 16), "rnd");
        end
        default: do_write(rs_r, d_r, $urandom_range(MINH, 16), "rnd");
      endcase
    end
    for (int k = 0; k < 128; k++) scan_chk(7'(k));

    // Reset in the middle of a clear fill.
    do_write(1'b0, 8'h38, 13, "r6_n");
    do_write(1'b0, 8'h06, 13, "r6_i");
    do_write(1'b0, 8'h85, 13, "r6_a05");
    do_write(1'b1, 8'h4B, 13, "r6_K");
    do_write(1'b0, 8'hE0, 13, "r6_a60");
    do_write(1'b1, 8'h57, 13, "r6_W");
    do_write(1'b0, 8'hB0, 13, "r6_a30");
    do_write(1'b1, 8'h51, 13, "r6_Q");
    @(negedge clk);
    bus.rs = 1'b0; bus.data = 8'h01; bus.en = 1'b1;
    repeat (13) @(negedge clk);
    bus.en = 1'b0;
    repeat (45) @(negedge clk);
    chk("fill/busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    m_reset_regs();
    chk("fill_rst/busy", 32'(busy), 32'd0);
    chk("fill_rst/rd_data", 32'(rd_data), 32'd0);
    chk("fill_rst/pulses", 32'({wr_stb, err}), 32'd0);
    chk_regs("fill_rst");
    @(negedge clk);
    rst = 1'b1;
    m_mem[7'h05] = 8'h20;
    repeat (2) @(negedge clk);
    scan_chk(7'h30); scan_chk(7'h60); scan_chk(7'h05);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
